// File: rtl/jk_counter_sequencer_pkg.sv
// Shared types for the JK counter run sequencer.
// State encoding and default counter width.
package jk_counter_sequencer_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/JKupcounter4bit.sv
// 4-bit synchronous up counter built from JK flip-flops.
// Active-low asynchronous clear; counts when count_enable is high.
module JKupcounter4bit (
  input  logic       clock,
  input  logic       clear,
  input  logic       count_enable,
  output logic [3:0] q
);

  logic [3:0] t;

  always_comb begin
    t[0] = count_enable;
    for (int i = 1; i < 4; i++) begin
      t[i] = t[i-1] & q[i-1];
    end
  end

  // J = K = t: characteristic equation q+ = J~q | ~Kq
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      q <= 4'd0;
    end else begin
      q <= (t & ~q) | (~t & q);
    end
  end

endmodule

// File: rtl/jk_counter_sequencer.sv
// Run controller for an external JK up counter.
// Clears, counts to a latched target, then stops or restarts.
module jk_counter_sequencer
  import jk_counter_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             abort,
  input  logic             periodic,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_enable,
  output logic             cnt_clear,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] run_count
);

  seq_state_t       state;
  seq_state_t       state_n;
  logic [WIDTH-1:0] tgt;
  logic             mode;
  logic             clr_q;
  logic             latch;
  logic             rc_inc;
  logic             hit;

  assign hit = (cnt_q == tgt);

  always_comb begin
    state_n = state;
    latch   = 1'b0;
    rc_inc  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_n = ST_CLR;
          latch   = 1'b1;
        end
      end
      ST_CLR: begin
        state_n = abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (hit) begin
          state_n = mode ? ST_CLR : ST_DONE;
          rc_inc  = mode;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // cnt_clear comes from a flop so the counter never sees a glitch
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= ST_IDLE;
      tgt       <= '0;
      mode      <= 1'b0;
      run_count <= '0;
      clr_q     <= 1'b0;
    end else begin
      state <= state_n;
      clr_q <= (state_n != ST_CLR);
      if (latch) begin
        tgt       <= target;
        mode      <= periodic;
        run_count <= '0;
      end else if (rc_inc) begin
        run_count <= run_count + WIDTH'(1);
      end
    end
  end

  assign cnt_clear  = clr_q;
  assign cnt_enable = (state == ST_RUN) && !hit;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_jk_counter_sequencer.sv
// Bench for jk_counter_sequencer driving an external JK counter.
// Vector table plus directed multi-cycle sequences.
module tb_jk_counter_sequencer;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       periodic = 1'b0;
  logic [3:0] target = 4'd0;
  logic [3:0] cnt_q;
  logic       cnt_enable;
  logic       cnt_clear;
  logic       busy;
  logic       done;
  logic [3:0] run_count;

  int total = 0;
  int passed = 0;

  always #5 clock = ~clock;

  jk_counter_sequencer #(.WIDTH(4)) dut (
    .clock(clock),
    .clear(clear),
    .start(start),
    .abort(abort),
    .periodic(periodic),
    .target(target),
    .cnt_q(cnt_q),
    .cnt_enable(cnt_enable),
    .cnt_clear(cnt_clear),
    .busy(busy),
    .done(done),
    .run_count(run_count)
  );

  JKupcounter4bit u_cnt (
    .clock(clock),
    .clear(cnt_clear),
    .count_enable(cnt_enable),
    .q(cnt_q)
  );

  typedef struct {
    logic       st;
    logic       ab;
    logic       per;
    logic [3:0] tg;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[14];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic [11:0] pk(input logic b, input logic d,
                                     input logic e, input logic c,
                                     input logic [3:0] q,
                                     input logic [3:0] r);
    return {b, d, e, c, q, r};
  endfunction

  task automatic run_one(input logic [3:0] t, input int pulse_at,
                         output int done_at, output int busy_cyc,
                         output int pulses, output int en_seen,
                         output int q_done);
    done_at = -1; busy_cyc = 0; pulses = 0; en_seen = 0; q_done = -1;
    start = 1'b1; periodic = 1'b0; target = t;
    tick();
    start = 1'b0;
    if (busy) busy_cyc++;
    if (cnt_enable) en_seen = 1;
    for (int n = 1; n < 60 && busy; n++) begin
      if (n == pulse_at) begin
        start = 1'b1;
        target = 4'd2;
      end
      tick();
      start = 1'b0;
      target = t;
      if (busy) busy_cyc++;
      if (cnt_enable) en_seen = 1;
      if (done) begin
        pulses++;
        if (done_at < 0) begin
          done_at = n;
          q_done = int'(cnt_q);
        end
      end
    end
  endtask

  int da, bc, pc, es, qd;
  int npulse;
  int en_any;

  initial begin
    // start, abort, periodic, target | busy done en clr q rc
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'd2, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0)};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 4'd0, pk(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0)};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'd0, pk(1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 4'd0)};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 4'd0, pk(1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd0)};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'd0, pk(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 4'd0)};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 4'd0, pk(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd0)};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 4'd5, pk(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd0)};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 4'd1, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0)};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'd0, pk(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0)};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'd0, pk(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0)};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 4'd0, pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1)};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 4'd0, pk(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1)};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 4'd0, pk(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1)};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 4'd0, pk(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1)};

    #2;
    chk("reset_outputs", int'(pk(busy, done, cnt_enable, cnt_clear,
                                 cnt_q, run_count)), 0);
    #10;
    clear = 1'b1;
    #1;
    chk("reset_clr_before_edge", int'(cnt_clear), 0);
    tick();
    chk("reset_clr_after_edge", int'(cnt_clear), 1);

    for (int i = 0; i < 14; i++) begin
      start = tbl[i].st;
      abort = tbl[i].ab;
      periodic = tbl[i].per;
      target = tbl[i].tg;
      tick();
      chk($sformatf("vec%0d", i),
          int'(pk(busy, done, cnt_enable, cnt_clear, cnt_q, run_count)),
          int'(tbl[i].exp));
    end
    start = 1'b0; abort = 1'b0; periodic = 1'b0; target = 4'd0;

    run_one(4'd9, -1, da, bc, pc, es, qd);
    chk("t9_done_at", da, 11);
    chk("t9_busy_cycles", bc, 12);
    chk("t9_done_pulses", pc, 1);
    chk("t9_q_at_done", qd, 9);
    chk("t9_q_hold", int'(cnt_q), 9);

    run_one(4'd0, -1, da, bc, pc, es, qd);
    chk("t0_done_at", da, 2);
    chk("t0_busy_cycles", bc, 3);
    chk("t0_enable_seen", es, 0);
    chk("t0_q", qd, 0);

    start = 1'b1; periodic = 1'b1; target = 4'd3;
    tick();
    start = 1'b0; periodic = 1'b0; target = 4'd0;
    npulse = 0;
    chk("per3_rc_e0", int'(run_count), 0);
    for (int n = 1; n < 20; n++) begin
      tick();
      if (done) npulse++;
      chk($sformatf("per3_rc_e%0d", n), int'(run_count), n / 5);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("per3_abort_busy", int'(busy), 0);
    chk("per3_abort_en", int'(cnt_enable), 0);
    chk("per3_abort_rc", int'(run_count), 3);
    tick();
    if (done) npulse++;
    tick();
    if (done) npulse++;
    chk("per3_abort_q", int'(cnt_q), 3);
    chk("per3_no_done", npulse, 0);

    start = 1'b1; target = 4'd9;
    tick();
    start = 1'b0;
    for (int n = 0; n < 6; n++) tick();
    chk("rst_mid_q", int'(cnt_q), 5);
    #2;
    clear = 1'b0;
    #1;
    chk("rst_mid_en", int'(cnt_enable), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_clr", int'(cnt_clear), 0);
    chk("rst_mid_cnt_q", int'(cnt_q), 0);
    #1;
    clear = 1'b1;
    tick();
    chk("rst_mid_clr_release", int'(cnt_clear), 1);
    chk("rst_mid_idle", int'(busy), 0);

    run_one(4'd7, 3, da, bc, pc, es, qd);
    chk("busy_start_done_at", da, 9);
    chk("busy_start_q", qd, 7);
    chk("busy_start_pulses", pc, 1);

    start = 1'b1; periodic = 1'b1; target = 4'd0;
    tick();
    start = 1'b0; periodic = 1'b0;
    en_any = 0;
    for (int n = 1; n <= 34; n++) begin
      tick();
      if (cnt_enable) en_any = 1;
      if (n == 2) chk("wrap_rc_p1", int'(run_count), 1);
      if (n == 30) chk("wrap_rc_p15", int'(run_count), 15);
      if (n == 32) chk("wrap_rc_p16", int'(run_count), 0);
      if (n == 34) chk("wrap_rc_p17", int'(run_count), 1);
    end
    chk("wrap_no_enable", en_any, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("wrap_abort_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
